// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised write ports, sweep-clear FSM.
// Optional same-cycle write-to-read forwarding when REG_FILE_MP_BYPASS_EN is defined.
module reg_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en0,
  input  logic [ADDR_W-1:0]        wr0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     wr_en1,
  input  logic [ADDR_W-1:0]        wr1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*ADDR_W-1:0] rr,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_open_c;
  logic acc0_c;
  logic acc1_c;

  // A write is accepted only outside the sweep and never to a hardwired zero register
  assign wr_open_c = (state == IDLE) || (state == DONE);
  assign acc0_c    = wr_en0 && wr_open_c && !(ZERO_REG && (wr0 == '0));
  assign acc1_c    = wr_en1 && wr_open_c && !(ZERO_REG && (wr1 == '0));

  // Sweep-clear sequencer with registered busy/done flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            state    <= CLEAR;
            ptr      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          ptr <= ptr + ADDR_W'(1);
          if (ptr == LAST_PTR) begin
            state    <= DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  // Storage: port 1 is applied last so it wins a same-address conflict
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (state == CLEAR) mem[ptr] <= '0;
      if (acc0_c) mem[wr0] <= wd0;
      if (acc1_c) mem[wr1] <= wd1;
    end
  end

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_c;

    assign ra = rr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd_c = mem[ra];
`ifdef REG_FILE_MP_BYPASS_EN
      if (acc0_c && (wr0 == ra)) rd_c = wd0;
      if (acc1_c && (wr1 == ra)) rd_c = wd1;
`endif
      if (ZERO_REG && (ra == '0)) rd_c = '0;
    end

    assign rd[k*DATA_W +: DATA_W] = rd_c;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (default parameters, two read ports).
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en0, wr_en1;
  logic [4:0]  wr0, wr1;
  logic [31:0] wd0, wd1;
  logic [9:0]  rr;
  logic [63:0] rd;
  logic        clr_req;
  logic        clr_busy, clr_done;

  int checks = 0;
  int errors = 0;
  int n;
  logic [31:0] exp0, exp1;

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk(clk), .reset(reset),
    .wr_en0(wr_en0), .wr0(wr0), .wd0(wd0),
    .wr_en1(wr_en1), .wr1(wr1), .wd1(wd1),
    .rr(rr), .rd(rd),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present two read addresses, sample at the following falling edge
  task automatic rd_chk(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] e0, input logic [31:0] e1);
    rr = {a1, a0};
    @(negedge clk);
    check({tag, "_p0"}, rd[31:0], e0);
    check({tag, "_p1"}, rd[63:32], e1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wr_en0  = 1'b0;
    wr_en1  = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic wr(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                    input logic e1, input logic [4:0] a1, input logic [31:0] d1);
    wr_en0 = e0; wr0 = a0; wd0 = d0;
    wr_en1 = e1; wr1 = a1; wd1 = d1;
    step();
  endtask

  initial begin
    reset = 1'b1;
    wr_en0 = 1'b0; wr0 = '0; wd0 = '0;
    wr_en1 = 1'b0; wr1 = '0; wd1 = '0;
    rr = '0; clr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    rd_chk("rst_rd_0_1", 5'd0, 5'd1, 32'h0, 32'h0);
    rd_chk("rst_rd_31", 5'd31, 5'd31, 32'h0, 32'h0);
    check("rst_busy", {31'b0, clr_busy}, 32'h0);
    check("rst_done", {31'b0, clr_done}, 32'h0);

    // Dual write, then read back
    step();
    wr(1'b1, 5'd1, 32'hA5A5_0001, 1'b1, 5'd2, 32'h0000_0012);
    rd_chk("dual_wr", 5'd1, 5'd2, 32'hA5A5_0001, 32'h0000_0012);

    // Same-address conflict and register 0
    step();
    wr(1'b1, 5'd7, 32'h1111_1111, 1'b1, 5'd7, 32'h2222_2222);
    wr(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    wr(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    rd_chk("conflict_zero", 5'd7, 5'd0, 32'h2222_2222, 32'h0);

    // Same-cycle visibility of a write
    step();
    rr = {5'd1, 5'd9};
    wr_en0 = 1'b1; wr0 = 5'd9; wd0 = 32'hDEAD_BEEF;
    @(negedge clk);
`ifdef REG_FILE_MP_BYPASS_EN
    check("bypass_same", rd[31:0], 32'hDEAD_BEEF);
`else
    check("bypass_same", rd[31:0], 32'h0);
`endif
    step();
    rd_chk("bypass_next", 5'd9, 5'd1, 32'hDEAD_BEEF, 32'hA5A5_0001);

    // Fill reg1..31 with their index
    step();
    for (int i = 1; i < 32; i++) wr(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 32'h0);
    rd_chk("fill", 5'd20, 5'd31, 32'h14, 32'h1F);

    // Full sweep: cycle c sits just after the (c-1)th edge following the request edge
    step();
    clr_req = 1'b1;
    step();
    for (int c = 1; c <= 32; c++) begin
      check($sformatf("sweep_busy_c%0d", c), {31'b0, clr_busy}, 32'h1);
      check($sformatf("sweep_done_c%0d", c), {31'b0, clr_done}, 32'h0);
      if (c == 11) rd_chk("mid_sweep", 5'd5, 5'd20, 32'h0, 32'h14);
      if (c == 5) clr_req = 1'b1;
      if (c == 20) begin wr_en0 = 1'b1; wr0 = 5'd3; wd0 = 32'h0000_0333; end
      if (c == 32) begin wr_en1 = 1'b1; wr1 = 5'd4; wd1 = 32'h0000_0444; end
      step();
    end
    check("sweep_done_c33", {31'b0, clr_done}, 32'h1);
    check("sweep_busy_c33", {31'b0, clr_busy}, 32'h0);
    // Writes accepted in DONE, clr_req in DONE ignored
    wr_en0 = 1'b1; wr0 = 5'd6; wd0 = 32'h0000_0066;
    clr_req = 1'b1;
    step();
    check("done_pulse_end", {31'b0, clr_done}, 32'h0);
    check("req_in_done_ign", {31'b0, clr_busy}, 32'h0);
    step();
    check("req_in_done_ign2", {31'b0, clr_busy}, 32'h0);
    for (int i = 0; i < 32; i += 2) begin
      exp0 = (i == 6) ? 32'h66 : 32'h0;
      exp1 = 32'h0;
      rd_chk($sformatf("post_sweep_%0d", i), 5'(i), 5'(i + 1), exp0, exp1);
    end

    // Reset in the middle of a sweep
    step();
    wr(1'b1, 5'd10, 32'h0000_00AA, 1'b1, 5'd25, 32'h0000_00BB);
    clr_req = 1'b1;
    step();
    repeat (4) step();
    check("abort_busy_pre", {31'b0, clr_busy}, 32'h1);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, clr_busy}, 32'h0);
    check("abort_done", {31'b0, clr_done}, 32'h0);
    rd_chk("abort_regs", 5'd25, 5'd6, 32'h0, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (clr_done) n++;
      step();
    end
    check("abort_no_done", 32'(n), 32'h0);

    // A later request performs a normal full sweep with DEPTH+1 latency
    wr(1'b1, 5'd12, 32'h0000_0012, 1'b0, 5'd0, 32'h0);
    clr_req = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!clr_done && n < 40);
    check("resweep_latency", 32'(n), 32'd33);
    rd_chk("resweep_regs", 5'd12, 5'd31, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file: successor to the single-write, dual-read register file in the single-cycle RISC-V core.
- Provides NUM_RD combinational read ports and two synchronous write ports with defined conflict priority.
- Register 0 can be hardwired to zero.
- A handshake-driven sweep FSM clears the whole array without asserting reset; the core uses it for context flush.

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers (power of two, ≥4)
- ADDR_W, $clog2(DEPTH), address width
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en0  in  1  write enable, port 0
- wr0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- wr_en1  in  1  write enable, port 1
- wr1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- rr  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd  out  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W]
- clr_req  in  1  single-cycle pulse; starts the sweep clear
- clr_busy  out  1  high while the sweep is active
- clr_done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset: asynchronous and active-high.
  - All DEPTH registers = 0; FSM = IDLE; clr_busy = 0; clr_done = 0; sweep pointer = 0.
  - Reset asserted mid-sweep aborts the sweep immediately. No clr_done pulse.
- Reads:
  - Combinational, zero latency: rd[k] = array[rr[k]].
  - With ZERO_REG=1, any read of address 0 returns 0.
- Writes:
  - Occur on the rising edge when wr_en is high and the FSM is IDLE or DONE.
  - Both ports enabled to the same address: port 1 wins; port 0 data is dropped.
  - With ZERO_REG=1, writes to address 0 are discarded.
  - Addresses ≥ DEPTH cannot occur (ADDR_W is exact).
- Sweep FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 → CLEAR with ptr=0. clr_busy rises on the next cycle.
  - CLEAR: each cycle array[ptr] ← 0 and ptr increments. ptr==DEPTH-1 → DONE.
    - All writes during CLEAR are discarded, including in the cycle the FSM leaves CLEAR.
    - clr_req during CLEAR is ignored.
    - clr_busy = 1 throughout CLEAR.
  - DONE: clr_done = 1 for exactly one cycle, clr_busy = 0, normal writes accepted → IDLE.
    - clr_req seen in DONE is ignored; the requester re-issues it once in IDLE.
- Sweep latency: clr_req edge to clr_done high = DEPTH+1 cycles. The array is fully zero from the clr_done cycle.
- Reads during CLEAR return current array contents: already-swept entries read 0, unswept entries keep their old value.
- clr_req and wr_en in the same IDLE cycle: the write commits; the sweep starts next cycle and erases it.

Optional Feature:
- Macro: REG_FILE_MP_BYPASS_EN.
- Defined:
  - A read whose address matches an enabled, accepted write in the same cycle returns the write data combinationally.
  - Port 1 has priority if both ports match.
  - No bypass for address 0 when ZERO_REG=1.
  - No bypass while clr_busy=1.
- Undefined: reads return the pre-edge stored value; new data is visible the cycle after the write.

Test Plan:
- Reset, then read addresses 0,1,31 on all ports → every rd = 32'h0, clr_busy=0, clr_done=0.
- Write wr0=1/wd0=32'hA5A5_0001 and wr1=2/wd1=32'h0000_0012 in one cycle; next cycle read rr=(1,2) → rd=(32'hA5A5_0001, 32'h0000_0012).
- Same-address conflict: wr0=wr1=7, wd0=32'h1111_1111, wd1=32'h2222_2222 → reg7 = 32'h2222_2222. Write 32'hFFFF_FFFF to address 0 → reads 0 (ZERO_REG=1).
- Fill reg1..31 with their index, pulse clr_req → clr_busy high for 32 cycles, clr_done pulses at cycle 33.
  - Mid-sweep at ptr=10: reg5 reads 0, reg20 reads 32'h14.
  - wr_en to reg3 during CLEAR is dropped.
  - Afterwards all registers read 0.
- Assert reset at sweep cycle 5 → clr_busy=0 immediately, all registers 0, no clr_done pulse; a later clr_req performs a normal full sweep.
- With REG_FILE_MP_BYPASS_EN: write reg9=32'hDEAD_BEEF while rr[0]=9 → rd[0]=32'hDEAD_BEEF in the same cycle. Without the macro → old value that cycle, 32'hDEAD_BEEF next cycle.
